// File: rtl/line_follow_pkg.sv
// Shared types and drive commands for the line-following controller.
// Optional PWM speed gating is enabled by defining PWM_SPEED_EN.
package line_follow_pkg;

  typedef enum logic [2:0] {
    ST_FOLLOW   = 3'd0,
    ST_JUNCTION = 3'd1,
    ST_AVOID    = 3'd2,
    ST_UTURN    = 3'd3,
    ST_LOST     = 3'd4,
    ST_HALT     = 3'd5
  } state_e;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } dir_e;

  typedef enum logic [2:0] {
    CL_FWD,
    CL_SPIN_L,
    CL_SPIN_R,
    CL_JUNC,
    CL_NONE
  } cls_e;

  localparam logic [3:0] CMD_FWD    = 4'b1010;
  localparam logic [3:0] CMD_SPIN_L = 4'b0110;
  localparam logic [3:0] CMD_SPIN_R = 4'b1001;
  localparam logic [3:0] CMD_STOP   = 4'b0000;

  function automatic logic [3:0] spin_cmd(dir_e d);
    return (d == LEFT) ? CMD_SPIN_L : CMD_SPIN_R;
  endfunction

  function automatic dir_e flip(dir_e d);
    return (d == LEFT) ? RIGHT : LEFT;
  endfunction

endpackage

// File: rtl/line_follow_ctrl_debounce.sv
// Two-flop synchroniser and stability debounce for active-low sensors.
// det_o follows ~raw_n_i once it has held for DEB_CYCLES cycles.
module sensor_debounce #(
  parameter int W          = 3,
  parameter int DEB_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] raw_n_i,
  output logic [W-1:0] det_o
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEB_CYCLES);

  logic [W-1:0]  s1_q, s2_q, det_q;
  logic [W-1:0]  det_nx, det_cur;
  logic [CW-1:0] cnt_q, cnt_d;

  // Compare the value about to enter det against the current one,
  // so a change restarts the count on the edge it lands.
  assign det_nx  = ~s1_q;
  assign det_cur = ~s2_q;

  always_comb begin
    cnt_d = cnt_q;
    if (det_nx != det_cur) cnt_d = '0;
    else if (cnt_q != CMAX) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q  <= '1;
      s2_q  <= '1;
      cnt_q <= '0;
      det_q <= '0;
    end else begin
      s1_q  <= raw_n_i;
      s2_q  <= s1_q;
      cnt_q <= cnt_d;
      if (cnt_d == CMAX) det_q <= det_nx;
    end
  end

  assign det_o = det_q;

endmodule

// File: rtl/line_follow_ctrl.sv
// Clocked line-follow steering FSM with junction, cone and lost handling.
// Define PWM_SPEED_EN to gate motor_en with a duty-cycle PWM.
import line_follow_pkg::*;

module line_follow_ctrl #(
  parameter int N_SENS       = 3,
  parameter int DEB_CYCLES   = 4,
  parameter int TURN_MIN     = 1000,
  parameter int LOST_TIMEOUT = 50000,
  parameter int PWM_BITS     = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_SENS-1:0]   induct_n,
  input  logic                proxim,
  input  logic                red,
  input  logic [PWM_BITS-1:0] duty,
  output logic [3:0]          motor_dir,
  output logic [1:0]          motor_en,
  output logic [2:0]          state_o,
  output logic                halted
);

  localparam int CTR = (N_SENS - 1) / 2;
  localparam int CW  = $clog2(N_SENS + 1);
  localparam int TW  = $clog2(TURN_MIN + 1);
  localparam int LW  = $clog2(LOST_TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX  = TW'(TURN_MIN);
  localparam logic [LW-1:0] LMAX  = LW'(LOST_TIMEOUT);
  localparam logic [LW-1:0] LLAST = LW'(LOST_TIMEOUT - 1);

  logic [N_SENS-1:0] det_q;
  logic prox_s1_q, prox_s2_q;
  logic red_s1_q, red_s2_q, red_d_q;
  logic red_rise, turn_done;
  logic [CW-1:0] l_cnt, r_cnt;
  cls_e       cls;
  logic [3:0] fol_cmd;
  dir_e       branch_nx;

  state_e        state_q;
  dir_e          branch_q;
  logic          cone_q, off_q, halt_q;
  logic [3:0]    last_q, dir_q;
  logic [1:0]    en_q;
  logic [TW-1:0] turn_q;
  logic [LW-1:0] lost_q;

  sensor_debounce #(
    .W          (N_SENS),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_deb (
    .clk     (clk),
    .rst     (rst),
    .raw_n_i (induct_n),
    .det_o   (det_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      prox_s1_q <= 1'b0;
      prox_s2_q <= 1'b0;
      red_s1_q  <= 1'b0;
      red_s2_q  <= 1'b0;
      red_d_q   <= 1'b0;
    end else begin
      prox_s1_q <= proxim;
      prox_s2_q <= prox_s1_q;
      red_s1_q  <= red;
      red_s2_q  <= red_s1_q;
      red_d_q   <= red_s2_q;
    end
  end

  assign red_rise  = red_s2_q & ~red_d_q;
  assign branch_nx = red_rise ? flip(branch_q) : branch_q;
  assign turn_done = (turn_q >= TMAX) && det_q[CTR];

  always_comb begin
    l_cnt = '0;
    r_cnt = '0;
    for (int i = 0; i < N_SENS; i++) begin
      if (i > CTR && det_q[i]) l_cnt = l_cnt + CW'(1);
      if (i < CTR && det_q[i]) r_cnt = r_cnt + CW'(1);
    end
    priority case (1'b1)
      (&det_q):       cls = CL_JUNC;
      (det_q == '0):  cls = CL_NONE;
      (l_cnt > r_cnt): cls = CL_SPIN_L;
      (r_cnt > l_cnt): cls = CL_SPIN_R;
      default:        cls = CL_FWD;
    endcase
  end

  always_comb begin
    unique case (cls)
      CL_SPIN_L: fol_cmd = CMD_SPIN_L;
      CL_SPIN_R: fol_cmd = CMD_SPIN_R;
      default:   fol_cmd = CMD_FWD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_FOLLOW;
      branch_q <= RIGHT;
      cone_q   <= 1'b0;
      off_q    <= 1'b0;
      last_q   <= CMD_FWD;
      turn_q   <= '0;
      lost_q   <= '0;
      dir_q    <= CMD_STOP;
      en_q     <= 2'b00;
      halt_q   <= 1'b0;
    end else if (state_q == ST_HALT) begin
      dir_q  <= CMD_STOP;
      en_q   <= 2'b00;
      halt_q <= 1'b1;
    end else begin
      branch_q <= branch_nx;
      en_q     <= 2'b11;
      if (turn_q != TMAX) turn_q <= turn_q + TW'(1);
      if (red_rise && cone_q) begin
        state_q <= ST_UTURN;
        cone_q  <= 1'b0;
        off_q   <= 1'b0;
        turn_q  <= '0;
        dir_q   <= spin_cmd(branch_nx);
      end else begin
        unique case (state_q)
          ST_FOLLOW: begin
            if (prox_s2_q) begin
              state_q <= ST_AVOID;
              cone_q  <= 1'b1;
              turn_q  <= '0;
              dir_q   <= spin_cmd(flip(branch_nx));
            end else if (cls == CL_JUNC) begin
              state_q <= ST_JUNCTION;
              turn_q  <= '0;
              dir_q   <= spin_cmd(branch_nx);
            end else if (cls == CL_NONE) begin
              state_q <= ST_LOST;
              lost_q  <= '0;
              dir_q   <= last_q;
            end else begin
              dir_q  <= fol_cmd;
              last_q <= fol_cmd;
            end
          end
          ST_JUNCTION: begin
            dir_q <= spin_cmd(branch_nx);
            if (turn_done) begin
              state_q <= ST_FOLLOW;
              dir_q   <= fol_cmd;
            end
          end
          ST_AVOID: begin
            dir_q <= spin_cmd(flip(branch_nx));
            if (turn_done) begin
              state_q <= ST_FOLLOW;
              dir_q   <= fol_cmd;
            end
          end
          ST_UTURN: begin
            dir_q <= spin_cmd(branch_nx);
            if (det_q == '0) off_q <= 1'b1;
            if (off_q && turn_done) begin
              state_q <= ST_FOLLOW;
              dir_q   <= fol_cmd;
            end
          end
          ST_LOST: begin
            dir_q <= last_q;
            if (|det_q) begin
              state_q <= ST_FOLLOW;
              lost_q  <= '0;
              dir_q   <= fol_cmd;
            end else if (lost_q == LLAST) begin
              state_q <= ST_HALT;
              lost_q  <= LMAX;
              dir_q   <= CMD_STOP;
              en_q    <= 2'b00;
              halt_q  <= 1'b1;
            end else begin
              lost_q <= lost_q + LW'(1);
            end
          end
          default: state_q <= ST_FOLLOW;
        endcase
      end
    end
  end

`ifdef PWM_SPEED_EN
  logic [PWM_BITS-1:0] pwm_q;

  always_ff @(posedge clk) begin
    if (rst) pwm_q <= '0;
    else     pwm_q <= pwm_q + PWM_BITS'(1);
  end

  assign motor_en = en_q & {2{pwm_q < duty}};
`else
  logic unused_duty;
  assign unused_duty = ^duty;
  assign motor_en    = en_q;
`endif

  assign motor_dir = dir_q;
  assign state_o   = state_q;
  assign halted    = halt_q;

endmodule

// File: tb/tb_line_follow_ctrl.sv
// Directed self-checking bench for line_follow_ctrl.
// Short TURN_MIN / LOST_TIMEOUT keep exact boundary checks cheap.
module tb_line_follow_ctrl;

  localparam int TM = 20;
  localparam int LT = 200;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] induct_n;
  logic       proxim, red;
  logic [7:0] duty;
  logic [3:0] motor_dir;
  logic [1:0] motor_en;
  logic [2:0] state_o;
  logic       halted;

  int n_tests = 0;
  int n_fail  = 0;

  line_follow_ctrl #(
    .N_SENS       (3),
    .DEB_CYCLES   (4),
    .TURN_MIN     (TM),
    .LOST_TIMEOUT (LT),
    .PWM_BITS     (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .induct_n  (induct_n),
    .proxim    (proxim),
    .red       (red),
    .duty      (duty),
    .motor_dir (motor_dir),
    .motor_en  (motor_en),
    .state_o   (state_o),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic red_pulse();
    red = 1'b1;
    tick(2);
    red = 1'b0;
    tick(3);
  endtask

  task automatic test_reset();
    rst = 1'b1; induct_n = 3'b111; proxim = 1'b0; red = 1'b0; duty = 8'd0;
    tick(3);
    n_tests++; if (motor_dir !== 4'b0000) begin n_fail++; $display("FAIL rst_dir got=%b exp=0000", motor_dir); end
    n_tests++; if (motor_en !== 2'b00) begin n_fail++; $display("FAIL rst_en got=%b exp=00", motor_en); end
    n_tests++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL rst_state got=%0d exp=0", state_o); end
    n_tests++; if (halted !== 1'b0) begin n_fail++; $display("FAIL rst_halted got=%b exp=0", halted); end
    rst = 1'b0; induct_n = 3'b101;
    tick(6);
    n_tests++; if (state_o !== 3'd4) begin n_fail++; $display("FAIL pre_lat_state got=%0d exp=4", state_o); end
    n_tests++; if (motor_dir !== 4'b1010) begin n_fail++; $display("FAIL pre_lat_dir got=%b exp=1010", motor_dir); end
    tick(1);
    n_tests++; if (motor_dir !== 4'b1010) begin n_fail++; $display("FAIL lat_dir got=%b exp=1010", motor_dir); end
    n_tests++; if (motor_en !== 2'b11) begin n_fail++; $display("FAIL lat_en got=%b exp=11", motor_en); end
    n_tests++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL lat_state got=%0d exp=0", state_o); end
  endtask

  task automatic test_steer();
    induct_n = 3'b001;
    tick(6);
    n_tests++; if (motor_dir !== 4'b1010) begin n_fail++; $display("FAIL spinl_early got=%b exp=1010", motor_dir); end
    tick(1);
    n_tests++; if (motor_dir !== 4'b0110) begin n_fail++; $display("FAIL spinl got=%b exp=0110", motor_dir); end
    induct_n = 3'b110;
    tick(2);
    induct_n = 3'b001;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      n_tests++;
      if (motor_dir !== 4'b0110) begin
        n_fail++; $display("FAIL glitch cyc=%0d got=%b exp=0110", i, motor_dir);
      end
    end
    induct_n = 3'b100;
    tick(7);
    n_tests++; if (motor_dir !== 4'b1001) begin n_fail++; $display("FAIL spinr got=%b exp=1001", motor_dir); end
    induct_n = 3'b101;
    tick(7);
    n_tests++; if (motor_dir !== 4'b1010) begin n_fail++; $display("FAIL fwd got=%b exp=1010", motor_dir); end
  endtask

  task automatic test_junction();
    induct_n = 3'b000;
    tick(7);
    n_tests++; if (state_o !== 3'd1) begin n_fail++; $display("FAIL junc1_state got=%0d exp=1", state_o); end
    n_tests++; if (motor_dir !== 4'b1001) begin n_fail++; $display("FAIL junc1_dir got=%b exp=1001", motor_dir); end
    induct_n = 3'b101;
    tick(TM);
    n_tests++; if (state_o !== 3'd1) begin n_fail++; $display("FAIL junc1_min got=%0d exp=1", state_o); end
    tick(1);
    n_tests++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL junc1_exit got=%0d exp=0", state_o); end
    n_tests++; if (motor_dir !== 4'b1010) begin n_fail++; $display("FAIL junc1_exdir got=%b exp=1010", motor_dir); end
    red_pulse();
    n_tests++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL red_follow got=%0d exp=0", state_o); end
    induct_n = 3'b000;
    tick(7);
    n_tests++; if (motor_dir !== 4'b0110) begin n_fail++; $display("FAIL junc2_dir got=%b exp=0110", motor_dir); end
    induct_n = 3'b101;
    tick(TM + 1);
    n_tests++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL junc2_exit got=%0d exp=0", state_o); end
  endtask

  task automatic test_cone_uturn();
    proxim = 1'b1;
    tick(1);
    proxim = 1'b0;
    tick(2);
    n_tests++; if (state_o !== 3'd2) begin n_fail++; $display("FAIL avoid_state got=%0d exp=2", state_o); end
    n_tests++; if (motor_dir !== 4'b1001) begin n_fail++; $display("FAIL avoid_dir got=%b exp=1001", motor_dir); end
    red = 1'b1;
    tick(2);
    red = 1'b0;
    tick(1);
    n_tests++; if (state_o !== 3'd3) begin n_fail++; $display("FAIL uturn_state got=%0d exp=3", state_o); end
    n_tests++; if (motor_dir !== 4'b1001) begin n_fail++; $display("FAIL uturn_dir got=%b exp=1001", motor_dir); end
    induct_n = 3'b111;
    tick(8);
    n_tests++; if (state_o !== 3'd3) begin n_fail++; $display("FAIL uturn_off got=%0d exp=3", state_o); end
    induct_n = 3'b101;
    tick(12);
    n_tests++; if (state_o !== 3'd3) begin n_fail++; $display("FAIL uturn_min got=%0d exp=3", state_o); end
    tick(1);
    n_tests++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL uturn_exit got=%0d exp=0", state_o); end
    n_tests++; if (motor_dir !== 4'b1010) begin n_fail++; $display("FAIL uturn_exdir got=%b exp=1010", motor_dir); end
    red_pulse();
    n_tests++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL cone_clr got=%0d exp=0", state_o); end
  endtask

  task automatic test_lost_halt();
    induct_n = 3'b001;
    tick(7);
    n_tests++; if (motor_dir !== 4'b0110) begin n_fail++; $display("FAIL lost_pre got=%b exp=0110", motor_dir); end
    induct_n = 3'b111;
    tick(7);
    n_tests++; if (state_o !== 3'd4) begin n_fail++; $display("FAIL lost_state got=%0d exp=4", state_o); end
    n_tests++; if (motor_dir !== 4'b0110) begin n_fail++; $display("FAIL lost_dir got=%b exp=0110", motor_dir); end
    n_tests++; if (motor_en !== 2'b11) begin n_fail++; $display("FAIL lost_en got=%b exp=11", motor_en); end
    tick(LT - 1);
    n_tests++; if (state_o !== 3'd4) begin n_fail++; $display("FAIL lost_edge got=%0d exp=4", state_o); end
    tick(1);
    n_tests++; if (state_o !== 3'd5) begin n_fail++; $display("FAIL halt_state got=%0d exp=5", state_o); end
    n_tests++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_flag got=%b exp=1", halted); end
    n_tests++; if (motor_en !== 2'b00) begin n_fail++; $display("FAIL halt_en got=%b exp=00", motor_en); end
    induct_n = 3'b101;
    tick(10);
    n_tests++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_stick got=%b exp=1", halted); end
    rst = 1'b1;
    tick(1);
    n_tests++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL halt_rst_state got=%0d exp=0", state_o); end
    n_tests++; if (halted !== 1'b0) begin n_fail++; $display("FAIL halt_rst_flag got=%b exp=0", halted); end
    rst = 1'b0;
  endtask

  task automatic test_rst_mid_turn();
    induct_n = 3'b000;
    tick(8);
    n_tests++; if (state_o !== 3'd1) begin n_fail++; $display("FAIL mid_junc got=%0d exp=1", state_o); end
    n_tests++; if (motor_dir !== 4'b1001) begin n_fail++; $display("FAIL mid_dir got=%b exp=1001", motor_dir); end
    rst = 1'b1;
    tick(1);
    n_tests++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL mid_rst_state got=%0d exp=0", state_o); end
    n_tests++; if (motor_dir !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_dir got=%b exp=0000", motor_dir); end
    n_tests++; if (motor_en !== 2'b00) begin n_fail++; $display("FAIL mid_rst_en got=%b exp=00", motor_en); end
    rst = 1'b0;
    induct_n = 3'b101;
    tick(10);
  endtask

`ifdef PWM_SPEED_EN
  task automatic test_pwm();
    int on_cnt;
    duty = 8'd64;
    on_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      tick(1);
      if (motor_en == 2'b11) on_cnt++;
    end
    n_tests++; if (on_cnt != 64) begin n_fail++; $display("FAIL pwm_on got=%0d exp=64", on_cnt); end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL timeout tests=%0d", n_tests);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_steer();
    test_junction();
    test_cone_uturn();
    test_lost_halt();
    test_rst_mid_turn();
`ifdef PWM_SPEED_EN
    test_pwm();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
